// File: rtl/sel_mux_if.sv
// Handshake bundle for sel_mux_pipe: N packed sources in, one registered selected word out.
interface sel_mux_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic                    err_clr;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready, err_clr,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready, err_clr,
    output in_ready, out_data, out_valid, sel_err
  );
endinterface

// File: rtl/sel_mux_pipe.sv
// N-way result selector with registered valid/ready output and a one-deep skid register.
// Optional SEL_MUX_STATS_EN adds a saturating 16-bit delivered-word counter (xfer_count).
module sel_mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sel_mux_if.slave    bus
`ifdef SEL_MUX_STATS_EN
  ,
  output logic [15:0] xfer_count
`endif
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int NSLOT = 1 << SEL_W;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] src [NSLOT];
  logic [WIDTH-1:0] sel_val, out_q, skid_q;
  logic             sel_bad, err_q;
  logic             in_ready, accept, deliver;
  logic             load_out, load_skid, move_skid;

  // Pad the source table to a power of two so the index never leaves the array.
  for (genvar k = 0; k < NSLOT; k++) begin : g_src
    if (k < NUM_IN) begin : g_real
      assign src[k] = bus.in_data[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign src[k] = '0;
    end
  end

  if (NSLOT > NUM_IN) begin : g_chk
    assign sel_bad = (bus.in_sel >= SEL_W'(NUM_IN));
  end else begin : g_nochk
    assign sel_bad = 1'b0;
  end

  assign sel_val = src[bus.in_sel];

  assign in_ready      = (state != FULL);
  assign accept        = bus.in_valid & in_ready;
  assign deliver       = (state != EMPTY) & bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = out_q;
  assign bus.sel_err   = err_q;

  always_comb begin
    state_nx  = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nx = ONE;
        load_out = 1'b1;
      end
      ONE: begin
        if (accept && !deliver) begin
          state_nx  = FULL;
          load_skid = 1'b1;
        end else if (accept) begin
          load_out = 1'b1;
        end else if (deliver) begin
          state_nx = EMPTY;
        end
      end
      FULL: if (deliver) begin
        state_nx  = ONE;
        move_skid = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
    // Flush wins over everything; the output register keeps stale data.
    if (bus.flush) begin
      state_nx  = EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_out)       out_q  <= sel_val;
      else if (move_skid) out_q  <= skid_q;
      if (load_skid)      skid_q <= sel_val;
      if (accept && sel_bad) err_q <= 1'b1;
      else if (bus.err_clr)  err_q <= 1'b0;
    end
  end

`ifdef SEL_MUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            xfer_count <= '0;
    else if (deliver && xfer_count != '1)  xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench for sel_mux_pipe: one 4-source instance and one 3-source instance.
module tb_sel_mux_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  always #5 clk = ~clk;

  sel_mux_if #(.WIDTH(32), .NUM_IN(4)) b4 ();
  sel_mux_if #(.WIDTH(32), .NUM_IN(3)) b3 ();

`ifdef SEL_MUX_STATS_EN
  logic [15:0] cnt4, cnt3;
`endif

  sel_mux_pipe #(.WIDTH(32), .NUM_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
`ifdef SEL_MUX_STATS_EN
    , .xfer_count(cnt4)
`endif
  );

  sel_mux_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
`ifdef SEL_MUX_STATS_EN
    , .xfer_count(cnt3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (b4.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", b4.out_valid); else pass_cnt++;
    chk_cnt++;
    if (b4.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", b4.in_ready); else pass_cnt++;
    chk_cnt++;
    if (b4.out_data !== 32'h0) $display("FAIL rst_out_data: got %h want 0", b4.out_data); else pass_cnt++;
    chk_cnt++;
    if (b3.sel_err !== 1'b0) $display("FAIL rst_sel_err: got %b want 0", b3.sel_err); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33; exp[3] = 32'h44;
    b4.out_ready = 1'b1;
    b4.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b4.in_sel = 2'(i);
      step();
      if (b4.out_data !== exp[i] || b4.out_valid !== 1'b1)
        $display("FAIL b2b_word%0d: got %h/v%b want %h/v1", i, b4.out_data, b4.out_valid, exp[i]);
      else pass_cnt++;
      chk_cnt++;
    end
    b4.in_valid = 1'b0;
    step();
    if (b4.out_valid !== 1'b0) $display("FAIL b2b_drain: got v%b want v0", b4.out_valid); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_stall();
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.in_sel    = 2'd1;
    step();
    if (b4.in_ready !== 1'b1 || b4.out_data !== 32'h22)
      $display("FAIL stall_one: got rdy%b %h want rdy1 22", b4.in_ready, b4.out_data);
    else pass_cnt++;
    chk_cnt++;
    b4.in_sel = 2'd2;
    step();
    if (b4.in_ready !== 1'b0 || b4.out_data !== 32'h22 || b4.out_valid !== 1'b1)
      $display("FAIL stall_full: got rdy%b %h v%b want rdy0 22 v1", b4.in_ready, b4.out_data, b4.out_valid);
    else pass_cnt++;
    chk_cnt++;
    // Still stalled: offered word 0x44 must not get in, output must hold.
    b4.in_sel = 2'd3;
    step();
    if (b4.out_data !== 32'h22) $display("FAIL stall_hold: got %h want 22", b4.out_data); else pass_cnt++;
    chk_cnt++;
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    step();
    if (b4.out_data !== 32'h33 || b4.out_valid !== 1'b1 || b4.in_ready !== 1'b1)
      $display("FAIL stall_skid: got %h v%b rdy%b want 33 v1 rdy1", b4.out_data, b4.out_valid, b4.in_ready);
    else pass_cnt++;
    chk_cnt++;
    step();
    if (b4.out_valid !== 1'b0) $display("FAIL stall_empty: got v%b want v0", b4.out_valid); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_sel_err();
    b3.out_ready = 1'b1;
    b3.in_valid  = 1'b1;
    b3.in_sel    = 2'd2;
    step();
    if (b3.out_data !== 32'hCC || b3.sel_err !== 1'b0)
      $display("FAIL err_last_src: got %h e%b want cc e0", b3.out_data, b3.sel_err);
    else pass_cnt++;
    chk_cnt++;
    b3.in_sel = 2'd3;
    step();
    if (b3.out_data !== 32'h0 || b3.sel_err !== 1'b1)
      $display("FAIL err_set: got %h e%b want 0 e1", b3.out_data, b3.sel_err);
    else pass_cnt++;
    chk_cnt++;
    b3.in_valid = 1'b0;
    b3.err_clr  = 1'b1;
    step();
    if (b3.sel_err !== 1'b0) $display("FAIL err_clr: got %b want 0", b3.sel_err); else pass_cnt++;
    chk_cnt++;
    b3.in_valid = 1'b1;
    step();
    if (b3.sel_err !== 1'b1) $display("FAIL err_set_beats_clr: got %b want 1", b3.sel_err); else pass_cnt++;
    chk_cnt++;
    b3.in_valid = 1'b0;
    b3.err_clr  = 1'b0;
    b3.flush    = 1'b1;
    step();
    b3.flush = 1'b0;
    if (b3.sel_err !== 1'b1) $display("FAIL err_flush_keep: got %b want 1", b3.sel_err); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_flush();
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.in_sel    = 2'd0;
    step();
    b4.in_sel = 2'd1;
    step();
    b4.in_sel = 2'd3;
    b4.flush  = 1'b1;
    step();
    b4.flush    = 1'b0;
    b4.in_valid = 1'b0;
    if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1)
      $display("FAIL flush_state: got v%b rdy%b want v0 rdy1", b4.out_valid, b4.in_ready);
    else pass_cnt++;
    chk_cnt++;
    b4.out_ready = 1'b1;
    step();
    step();
    if (b4.out_valid !== 1'b0) $display("FAIL flush_no_deliver: got v%b want v0", b4.out_valid); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_async_reset();
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.in_sel    = 2'd2;
    step();
    b4.in_sel = 2'd3;
    step();
    b4.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1 || b4.out_data !== 32'h0)
      $display("FAIL async_rst: got v%b rdy%b %h want v0 rdy1 0", b4.out_valid, b4.in_ready, b4.out_data);
    else pass_cnt++;
    chk_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    b4.out_ready = 1'b1;
    step();
    if (b4.out_valid !== 1'b0) $display("FAIL post_rst_idle: got v%b want v0", b4.out_valid); else pass_cnt++;
    chk_cnt++;
  endtask

`ifdef SEL_MUX_STATS_EN
  task automatic test_stats();
    if (cnt4 !== 16'h0) $display("FAIL stats_zero: got %h want 0", cnt4); else pass_cnt++;
    chk_cnt++;
    b4.out_ready = 1'b1;
    b4.in_valid  = 1'b1;
    b4.in_sel    = 2'd0;
    step();
    for (int i = 0; i < 70000; i++) step();
    b4.in_valid = 1'b0;
    step();
    if (cnt4 !== 16'hFFFF) $display("FAIL stats_sat: got %h want ffff", cnt4); else pass_cnt++;
    chk_cnt++;
  endtask
`endif

  initial begin
    b4.in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    b4.in_sel = '0; b4.in_valid = 1'b0; b4.flush = 1'b0; b4.out_ready = 1'b0; b4.err_clr = 1'b0;
    b3.in_data = {32'hCC, 32'hBB, 32'hAA};
    b3.in_sel = '0; b3.in_valid = 1'b0; b3.flush = 1'b0; b3.out_ready = 1'b0; b3.err_clr = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_back_to_back();
    test_stall();
    test_sel_err();
    test_flush();
    test_async_reset();
`ifdef SEL_MUX_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
